// File: rtl/sram_cache_pkg.sv
// Shared definitions for the two-port SRAM cache arbiter: controller states,
// port count and the round-robin grant helper.
package sram_cache_pkg;

  localparam int NUM_PORTS = 2;

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } cache_state_e;

  // prio names the port that wins when both ports request.
  function automatic logic [NUM_PORTS-1:0] rr_grant(input logic [NUM_PORTS-1:0] req,
                                                    input logic                 prio);
    logic [NUM_PORTS-1:0] gnt;
    gnt = req;
    if (&req) begin
      gnt = prio ? 2'b10 : 2'b01;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/sram_cache.sv
// Single-port cache storage: byte-enabled writes, one-cycle registered read.
// TECHNO_CUT picks generic byte-lane arrays (0) or one bit-masked wide array (non-zero).
module sram_cache #(
  parameter  int DATA_WIDTH = 64,
  parameter  int USER_WIDTH = 1,
  parameter  int USER_EN    = 0,
  parameter  int NUM_WORDS  = 1024,
  parameter  int TECHNO_CUT = 0,
  localparam int AW         = $clog2(NUM_WORDS),
  localparam int BE_W       = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clk_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [BE_W-1:0]       be_i,
  input  logic [USER_WIDTH-1:0] wuser_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [USER_WIDTH-1:0] ruser_o
);

  genvar gi;

  if (TECHNO_CUT == 0) begin : g_lanes
    for (gi = 0; gi < BE_W; gi++) begin : g_lane
      localparam int LO = gi * 8;
      localparam int LW = (DATA_WIDTH - LO >= 8) ? 8 : DATA_WIDTH - LO;

      logic [LW-1:0] mem [NUM_WORDS];
      logic [LW-1:0] rd_reg;

      always_ff @(posedge clk_i) begin
        if (req_i && we_i && be_i[gi]) begin
          mem[addr_i] <= wdata_i[LO +: LW];
        end
        if (req_i && !we_i) begin
          rd_reg <= mem[addr_i];
        end
      end

      assign rdata_o[LO +: LW] = rd_reg;
    end
  end else begin : g_cut
    logic [DATA_WIDTH-1:0] bit_mask;
    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
    logic [DATA_WIDTH-1:0] rd_reg;

    // Macro cuts take a per-bit write mask rather than byte enables.
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_mask
      assign bit_mask[gi] = be_i[gi / 8];
    end

    always_ff @(posedge clk_i) begin
      if (req_i && we_i) begin
        for (int i = 0; i < DATA_WIDTH; i++) begin
          if (bit_mask[i]) begin
            mem[addr_i][i] <= wdata_i[i];
          end
        end
      end
      if (req_i && !we_i) begin
        rd_reg <= mem[addr_i];
      end
    end

    assign rdata_o = rd_reg;
  end

  if (USER_EN != 0) begin : g_user
    logic [USER_WIDTH-1:0] umem [NUM_WORDS];
    logic [USER_WIDTH-1:0] ruser_reg;

    // User bits follow every write regardless of byte enables.
    always_ff @(posedge clk_i) begin
      if (req_i) begin
        if (we_i) begin
          umem[addr_i] <= wuser_i;
        end else begin
          ruser_reg <= umem[addr_i];
        end
      end
    end

    assign ruser_o = ruser_reg;
  end else begin : g_no_user
    logic unused_wuser;
    assign unused_wuser = ^wuser_i;
    assign ruser_o      = '0;
  end

endmodule

// File: rtl/sram_cache_arbiter.sv
// Two-port round-robin front end for one sram_cache; clears the whole array
// after reset and on flush, granting nothing while that sweep runs.
module sram_cache_arbiter
  import sram_cache_pkg::*;
#(
  parameter  int DATA_WIDTH = 64,
  parameter  int USER_WIDTH = 1,
  parameter  int USER_EN    = 0,
  parameter  int NUM_WORDS  = 1024,
  parameter  int TECHNO_CUT = 0,
  localparam int AW         = $clog2(NUM_WORDS),
  localparam int BE_W       = (DATA_WIDTH + 7) / 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  output logic                            busy_o,
  input  logic [NUM_PORTS-1:0]            req_i,
  output logic [NUM_PORTS-1:0]            gnt_o,
  input  logic [NUM_PORTS-1:0]            we_i,
  input  logic [NUM_PORTS*AW-1:0]         addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_PORTS*BE_W-1:0]       be_i,
  input  logic [NUM_PORTS*USER_WIDTH-1:0] wuser_i,
  output logic [NUM_PORTS-1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0]           rdata_o,
  output logic [USER_WIDTH-1:0]           ruser_o
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_WORDS - 1);

  cache_state_e         state_reg, state_next;
  logic [AW-1:0]        sweep_cnt_reg, sweep_cnt_next;
  logic                 rr_prio_reg, rr_prio_next;
  logic [NUM_PORTS-1:0] rvalid_reg, rvalid_next;
  logic [NUM_PORTS-1:0] gnt;

  logic [AW-1:0]         port_addr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] port_wdata [NUM_PORTS];
  logic [BE_W-1:0]       port_be    [NUM_PORTS];
  logic [USER_WIDTH-1:0] port_wuser [NUM_PORTS];

  logic                  sram_req;
  logic                  sram_we;
  logic [AW-1:0]         sram_addr;
  logic [DATA_WIDTH-1:0] sram_wdata;
  logic [BE_W-1:0]       sram_be;
  logic [USER_WIDTH-1:0] sram_wuser;

  genvar gi;

  for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign port_addr[gi]  = addr_i[gi*AW +: AW];
    assign port_wdata[gi] = wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
    assign port_be[gi]    = be_i[gi*BE_W +: BE_W];
    assign port_wuser[gi] = wuser_i[gi*USER_WIDTH +: USER_WIDTH];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= SWEEP;
      sweep_cnt_reg <= '0;
      rr_prio_reg   <= 1'b0;
      rvalid_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      sweep_cnt_reg <= sweep_cnt_next;
      rr_prio_reg   <= rr_prio_next;
      rvalid_reg    <= rvalid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    sweep_cnt_next = sweep_cnt_reg;
    rr_prio_next   = rr_prio_reg;
    // Read data is registered in the SRAM, so a granted read returns next cycle
    // even if a flush sweep has started by then.
    rvalid_next    = gnt & ~we_i;
    case (state_reg)
      SWEEP: begin
        if (sweep_cnt_reg == LAST_ADDR) begin
          state_next     = RUN;
          sweep_cnt_next = '0;
        end else begin
          sweep_cnt_next = sweep_cnt_reg + AW'(1);
        end
      end
      RUN: begin
        if (flush_i) begin
          state_next     = SWEEP;
          sweep_cnt_next = '0;
        end else if (|gnt) begin
          rr_prio_next = gnt[0];
        end
      end
      default: state_next = SWEEP;
    endcase
  end

  always_comb begin
    gnt        = '0;
    busy_o     = 1'b0;
    sram_req   = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = sweep_cnt_reg;
    sram_wdata = '0;
    sram_be    = '1;
    sram_wuser = '0;
    case (state_reg)
      SWEEP: begin
        busy_o   = 1'b1;
        sram_req = 1'b1;
        sram_we  = 1'b1;
      end
      RUN: begin
        if (!flush_i) begin
          gnt        = rr_grant(req_i, rr_prio_reg);
          sram_req   = |gnt;
          sram_we    = |(gnt & we_i);
          sram_addr  = port_addr[gnt[1]];
          sram_wdata = port_wdata[gnt[1]];
          sram_be    = port_be[gnt[1]];
          sram_wuser = port_wuser[gnt[1]];
        end
      end
      default: ;
    endcase
  end

  assign gnt_o    = gnt;
  assign rvalid_o = rvalid_reg;

  sram_cache #(
    .DATA_WIDTH (DATA_WIDTH),
    .USER_WIDTH (USER_WIDTH),
    .USER_EN    (USER_EN),
    .NUM_WORDS  (NUM_WORDS),
    .TECHNO_CUT (TECHNO_CUT)
  ) u_sram (
    .clk_i   (clk_i),
    .req_i   (sram_req),
    .we_i    (sram_we),
    .addr_i  (sram_addr),
    .wdata_i (sram_wdata),
    .be_i    (sram_be),
    .wuser_i (sram_wuser),
    .rdata_o (rdata_o),
    .ruser_o (ruser_o)
  );

endmodule

// File: tb/tb_sram_cache_arbiter.sv
// Scoreboard bench for sram_cache_arbiter: a behavioural model predicts grants,
// sweep timing and read data; expected reads are queued and popped on rvalid.
module tb_sram_cache_arbiter;

  localparam int DW = 64;
  localparam int UW = 1;
  localparam int NW = 16;
  localparam int AW = 4;
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          busy;
  logic [1:0]    req = '0;
  logic [1:0]    gnt;
  logic [1:0]    we = '0;
  logic [2*AW-1:0] addr = '0;
  logic [2*DW-1:0] wdata = '0;
  logic [2*BW-1:0] be = '0;
  logic [2*UW-1:0] wuser = '0;
  logic [1:0]    rvalid;
  logic [DW-1:0] rdata;
  logic [UW-1:0] ruser;

  always #5 clk = ~clk;

  sram_cache_arbiter #(
    .DATA_WIDTH (DW),
    .USER_WIDTH (UW),
    .USER_EN    (1),
    .NUM_WORDS  (NW),
    .TECHNO_CUT (0)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .flush_i  (flush),
    .busy_o   (busy),
    .req_i    (req),
    .gnt_o    (gnt),
    .we_i     (we),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .be_i     (be),
    .wuser_i  (wuser),
    .rvalid_o (rvalid),
    .rdata_o  (rdata),
    .ruser_o  (ruser)
  );

  // Staged stimulus, applied to the DUT at each falling edge.
  logic          s_rst_n = 1'b0;
  logic          s_flush = 1'b0;
  logic [1:0]    s_req = '0;
  logic [1:0]    s_we = '0;
  logic [AW-1:0] s_addr  [2];
  logic [DW-1:0] s_wdata [2];
  logic [BW-1:0] s_be    [2];
  logic [UW-1:0] s_user  [2];

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    logic [UW-1:0] user;
  } rd_t;

  rd_t           rv_q[$];
  logic [DW-1:0] mem_m  [NW];
  logic [UW-1:0] umem_m [NW];
  int            sweep_left = NW;
  logic          prio_m = 1'b0;
  logic [1:0]    last_gnt;
  logic          last_busy;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NW; i++) begin
      mem_m[i]  = '0;
      umem_m[i] = '0;
    end
  endtask

  task automatic tick();
    logic [1:0]    eg;
    logic          eb;
    logic [1:0]    ev;
    logic [DW-1:0] w;
    rd_t           e;
    int            p;
    @(negedge clk);
    rst_n = s_rst_n;
    flush = s_flush;
    req   = s_req;
    we    = s_we;
    for (int i = 0; i < 2; i++) begin
      addr[i*AW +: AW]  = s_addr[i];
      wdata[i*DW +: DW] = s_wdata[i];
      be[i*BW +: BW]    = s_be[i];
      wuser[i*UW +: UW] = s_user[i];
    end
    #1;
    if (!s_rst_n) rv_q.delete();
    eb = !s_rst_n || (sweep_left > 0);
    eg = '0;
    if (!eb && !s_flush) eg = (s_req == 2'b11) ? (prio_m ? 2'b10 : 2'b01) : s_req;
    check("busy", 64'(busy), 64'(eb));
    check("gnt", 64'(gnt), 64'(eg));
    if (rv_q.size() > 0) begin
      e  = rv_q.pop_front();
      ev = (e.port == 1) ? 2'b10 : 2'b01;
      check("rvalid", 64'(rvalid), 64'(ev));
      check("rdata", rdata, e.data);
      check("ruser", 64'(ruser), 64'(e.user));
    end else begin
      check("rvalid_idle", 64'(rvalid), 64'(0));
    end
    last_gnt  = gnt;
    last_busy = busy;
    // Advance the model across the coming rising edge.
    if (!s_rst_n) begin
      sweep_left = NW;
      prio_m     = 1'b0;
      clear_model();
    end else if (sweep_left > 0) begin
      sweep_left--;
    end else if (s_flush) begin
      sweep_left = NW;
      clear_model();
    end else if (eg != 2'b00) begin
      p      = eg[1] ? 1 : 0;
      prio_m = (p == 0);
      if (s_we[p]) begin
        w = mem_m[s_addr[p]];
        for (int b = 0; b < BW; b++) begin
          if (s_be[p][b]) w[b*8 +: 8] = s_wdata[p][b*8 +: 8];
        end
        mem_m[s_addr[p]]  = w;
        umem_m[s_addr[p]] = s_user[p];
        $display("t=%0t port%0d write addr=%0d be=%h data=%h", $time, p, s_addr[p], s_be[p], s_wdata[p]);
      end else begin
        e.port = p;
        e.data = mem_m[s_addr[p]];
        e.user = umem_m[s_addr[p]];
        rv_q.push_back(e);
        $display("t=%0t port%0d read  addr=%0d expect=%h", $time, p, s_addr[p], e.data);
      end
    end
  endtask

  task automatic idle();
    s_req = '0;
    s_we  = '0;
  endtask

  task automatic set_op(input int p, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] b, input logic [UW-1:0] u);
    s_req[p]   = 1'b1;
    s_we[p]    = w;
    s_addr[p]  = a;
    s_wdata[p] = d;
    s_be[p]    = b;
    s_user[p]  = u;
  endtask

  task automatic sweep_len(input string tag);
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (last_busy) n++;
      else break;
    end
    check(tag, 64'(n), 64'(NW));
  endtask

  logic [1:0] rr_exp [6];

  initial begin
    rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 2; i++) begin
      s_addr[i] = '0; s_wdata[i] = '0; s_be[i] = '0; s_user[i] = '0;
    end
    clear_model();

    // Reset with both ports requesting: no grant, busy high.
    s_req = 2'b11;
    repeat (3) tick();
    idle();
    s_rst_n = 1'b1;
    sweep_len("sweep_after_reset");

    // Read of a freshly cleared word.
    set_op(0, 1'b0, 4'd5, '0, '0, '0);
    tick();
    idle();
    tick();

    // Write then read from the other port.
    set_op(0, 1'b1, 4'd3, 64'hDEADBEEF, 8'hFF, 1'b1);
    tick();
    idle();
    set_op(1, 1'b0, 4'd3, '0, '0, '0);
    tick();
    idle();
    tick();

    // Partial byte-enable merge.
    set_op(0, 1'b1, 4'd2, 64'h1122334455667788, 8'hFF, 1'b0);
    tick();
    set_op(0, 1'b1, 4'd2, 64'h00000000000000AB, 8'h01, 1'b1);
    tick();
    idle();
    set_op(1, 1'b0, 4'd2, '0, '0, '0);
    tick();
    idle();
    tick();

    // Write ones, read it, flush while port 0 waits; read survives, then cleared.
    set_op(1, 1'b1, 4'd7, '1, 8'hFF, 1'b1);
    tick();
    idle();
    set_op(1, 1'b0, 4'd7, '0, '0, '0);
    tick();
    idle();
    set_op(0, 1'b0, 4'd7, '0, '0, '0);
    s_flush = 1'b1;
    tick();
    check("flush_gnt", 64'(last_gnt), 64'(0));
    s_flush = 1'b0;
    sweep_len("sweep_after_flush");
    idle();
    tick();

    // Reset in the middle of a sweep at counter 9.
    s_rst_n = 1'b0;
    tick();
    s_rst_n = 1'b1;
    repeat (9) tick();
    s_rst_n = 1'b0;
    tick();
    tick();
    s_rst_n = 1'b1;
    sweep_len("sweep_restart");

    // Both ports requesting from the reset pointer.
    set_op(0, 1'b0, 4'd1, '0, '0, '0);
    set_op(1, 1'b0, 4'd2, '0, '0, '0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rr_seq", 64'(last_gnt), 64'(rr_exp[i]));
    end
    idle();
    tick();

    // Mixed random traffic with occasional flushes.
    for (int i = 0; i < 80; i++) begin
      for (int p = 0; p < 2; p++) begin
        s_req[p]   = $urandom_range(0, 1) == 1;
        s_we[p]    = $urandom_range(0, 1) == 1;
        s_addr[p]  = AW'($urandom_range(0, NW - 1));
        s_wdata[p] = {$urandom, $urandom};
        s_be[p]    = BW'($urandom);
        s_user[p]  = UW'($urandom);
      end
      s_flush = ($urandom_range(0, 24) == 0);
      tick();
    end
    s_flush = 1'b0;
    idle();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_cache_arbiter.md
SRAM_CACHE_ARBITER -- requirements
Module: sram_cache_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set the data word width.
REQ-002 Parameter USER_WIDTH, default 1, SHALL set the user sideband width.
REQ-003 Parameter USER_EN, default 0, SHALL enable user sideband storage (0: ruser_o reads 0).
REQ-004 Parameter NUM_WORDS, default 1024, SHALL set the SRAM depth; AW = $clog2(NUM_WORDS).
REQ-005 Parameter TECHNO_CUT, default 0, SHALL be passed through to the SRAM macro wrapper.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-007 clk_i  in  1  clock.
REQ-008 rst_ni  in  1  asynchronous active-low reset.
REQ-009 flush_i  in  1  request to clear the whole array.
REQ-010 busy_o  out  1  high while an init/flush sweep runs.
REQ-011 req_i  in  2  per-port access request (port 0, port 1).
REQ-012 gnt_o  out  2  per-port grant, one-hot or zero.
REQ-013 we_i  in  2  per-port write enable.
REQ-014 addr_i  in  2*AW  per-port word address (port p in bits [p*AW +: AW]).
REQ-015 wdata_i  in  2*DATA_WIDTH  per-port write data.
REQ-016 be_i  in  2*((DATA_WIDTH+7)/8)  per-port byte enables.
REQ-017 wuser_i  in  2*USER_WIDTH  per-port write user bits.
REQ-018 rvalid_o  out  2  per-port read-data valid, one-hot or zero.
REQ-019 rdata_o  out  DATA_WIDTH  shared read data, valid when any rvalid_o bit is high.
REQ-020 ruser_o  out  USER_WIDTH  shared read user bits, qualified like rdata_o.

Function
REQ-021 The FSM SHALL have states SWEEP and RUN.
REQ-022 In SWEEP: one SRAM write per cycle at sweep counter address, data 0, user 0, all byte enables set; gnt_o = 0; busy_o = 1.
REQ-023 Sweep counter SHALL start at 0 and go to RUN the cycle after writing address NUM_WORDS-1; non-power-of-2 NUM_WORDS SHALL be supported (no write beyond NUM_WORDS-1).
REQ-024 In RUN with flush_i = 0, any req_i high SHALL grant exactly one port combinationally in the same cycle and issue that port's access to the SRAM in that cycle.
REQ-025 Both ports requesting SHALL be arbitrated round-robin: the port not granted last wins; a single requester always wins.
REQ-026 The round-robin pointer SHALL update only on a grant.
REQ-027 A granted read SHALL assert rvalid_o for that port exactly one cycle after the grant, with rdata_o/ruser_o from the SRAM; granted writes SHALL produce no rvalid_o.
REQ-028 Back-to-back grants SHALL be allowed every cycle (throughput 1 access/cycle).
REQ-029 flush_i = 1 in RUN SHALL suppress all grants that cycle and enter SWEEP at counter 0 on the next cycle.
REQ-030 A read granted in the cycle before a flush SHALL still deliver its rvalid_o during the first SWEEP cycle.
REQ-031 flush_i during SWEEP SHALL be ignored (sweep not restarted).
REQ-032 Requesters SHALL hold req_i and payload until granted; the block SHALL NOT buffer ungranted requests.

Reset
REQ-033 On reset assertion: state = SWEEP, sweep counter = 0, round-robin favours port 0, rvalid_o = 0, gnt_o = 0, busy_o = 1.
REQ-034 Reset asserted mid-sweep SHALL restart the sweep from address 0 after release.
REQ-035 rdata_o/ruser_o values SHALL be don't-care while rvalid_o = 0.

Structure
REQ-036 State enumeration and port count (2) SHALL be defined in the shared cache package.
REQ-037 The block SHALL instantiate exactly one sram_cache as its storage sub-module; all SRAM traffic passes through its single port.

Verification
REQ-038 Reset release, NUM_WORDS=16: busy_o high exactly 16 cycles, no gnt_o; then read addr 5 -> rvalid_o[0] next cycle, rdata_o = 0.
REQ-039 Port 0 writes 0xDEADBEEF to addr 3, be all ones; port 1 reads addr 3 next cycle -> rvalid_o[1] one cycle later, rdata_o = 0xDEADBEEF.
REQ-040 Both ports request continuously for 6 cycles from reset-state pointer -> grants 0,1,0,1,0,1, one per cycle.
REQ-041 Write 0xFF.. to addr 7, assert flush_i one cycle with port 0 requesting -> no grant that cycle, busy_o high NUM_WORDS cycles, then read addr 7 returns 0.
REQ-042 Byte-enable write be=0x01 data 0xAB to addr 2 over prior 0x1122334455667788 -> read returns 0x11223344556677AB.
REQ-043 Assert rst_ni low mid-sweep at counter 9 -> after release sweep restarts at 0, busy_o high full NUM_WORDS cycles.
